mpu_ls_controller: RTL
======================

Name: mpu_ls_controller

Overview:
Sequencer for the MPU load/store datapath. It accepts one matrix operation at a time over a valid/ready handshake and checks it for legality. It then drives the enable of mpu_load or mpu_store, waits for completion, error or timeout, and reports the outcome. It also keeps a per-register valid scoreboard, so a store from a matrix register that was never loaded is rejected before the datapath is touched.

Parameters:
NUM_REGS, 2**MATRIX_REG_SIZE, number of matrix registers tracked by the scoreboard
TIMEOUT_CYCLES, 64, maximum cycles an enable may stay high without completion (minimum 2)
M, global_defs M, maximum legal row count
N, global_defs N, maximum legal column count

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
op_valid_in  in  1  operation request
op_ready_out  out  1  controller can accept an operation
op_in  in  mpu_operation_t  NOP / LOAD / STORE
op_addr_in  in  MATRIX_REG_SIZE  target matrix register
op_m_in  in  MBITS+1  row count
op_n_in  in  NBITS+1  column count
load_en_out  out  1  enable to mpu_load
store_en_out  out  1  enable to mpu_store
mem_load_ack_in  in  1  load finished (from mpu_load)
mem_load_error_in  in  1  load failed (from mpu_load)
reg_store_complete_in  in  1  store finished (from register file)
ctrl_addr_out  out  MATRIX_REG_SIZE  latched register address
ctrl_m_out  out  MBITS+1  latched row count
ctrl_n_out  out  NBITS+1  latched column count
done_out  out  1  one-cycle success pulse
error_out  out  1  one-cycle failure pulse
error_code_out  out  3  mpu_ctrl_err_t, cause of the last failure
reg_valid_out  out  NUM_REGS  scoreboard of loaded registers

Behaviour:
- Reset (rst low, asynchronous): state IDLE; all outputs 0; op_ready_out 0 while rst is low; scoreboard cleared; enables drop immediately, even mid-operation.
- States: IDLE, CHECK, LOAD, STORE, DONE, ERROR.
- IDLE: op_ready_out=1.
  - Accept on posedge with op_valid_in && op_ready_out.
  - On accept: latch op, addr, m and n into ctrl_* (they stay stable until the next accept); clear error_code_out to ERR_NONE; go to CHECK.
- CHECK (1 cycle, op_ready_out=0). Checks run in this priority order:
  - Illegal op encoding -> ERROR, code ERR_ILLEGAL_OP.
  - NOP -> DONE.
  - LOAD/STORE with m==0, m>M, n==0 or n>N -> ERROR, code ERR_SIZE.
  - STORE with reg_valid_out[addr]==0 -> ERROR, code ERR_INVALID_REG.
  - Otherwise -> LOAD or STORE.
- LOAD: load_en_out=1 (level); timeout counter starts at 0 on entry and increments each cycle.
  - mem_load_error_in -> ERROR, code ERR_MEM. Error wins if error and ack arrive in the same cycle.
  - mem_load_ack_in -> DONE; set reg_valid_out[addr] on the DONE transition.
  - counter == TIMEOUT_CYCLES-1 with neither input -> ERROR, code ERR_TIMEOUT. An ack in that same cycle wins over the timeout.
- STORE: store_en_out=1.
  - reg_store_complete_in -> DONE.
  - Same timeout rule as LOAD.
  - Scoreboard is unchanged.
- DONE: done_out=1 for one cycle, enables 0 -> IDLE.
- ERROR: error_out=1 for one cycle, enables 0 -> IDLE. error_code_out holds until the next accept.
- Enable timing:
  - Enables are registered; high from the cycle after CHECK until the completion cycle inclusive.
  - At least one idle cycle with enables low between consecutive operations.
- Latency: accept at T0.
  - NOP: done_out at T2.
  - LOAD with ack at cycle Tk: done_out at Tk+1.
  - Minimum LOAD/STORE: enable at T2, ack at T2, done_out at T3.
- Completion inputs arriving in IDLE, CHECK, DONE or ERROR are ignored.
- A failed LOAD (error or timeout) does not change the scoreboard; a previously valid register stays valid.
- Reloading an already-valid register is legal.

Decomposition:
- Add to mpu_pkg:
  - typedef enum mpu_ctrl_state_t {IDLE, CHECK, LOAD, STORE, DONE, ERROR}.
  - typedef enum logic [2:0] mpu_ctrl_err_t {ERR_NONE=0, ERR_SIZE=1, ERR_INVALID_REG=2, ERR_MEM=3, ERR_TIMEOUT=4, ERR_ILLEGAL_OP=5}.
  - localparam CTRL_TIMEOUT_DEFAULT=64.
- One sub-module: mpu_ctrl_timeout. It is a resettable down-counter with load, enable and expired outputs, parameterised by TIMEOUT_CYCLES.

Test Plan:
1. Reset, then NOP (m=2, n=2, addr=0) -> op_ready_out low T1-T2, done_out pulse at T2, load_en_out and store_en_out never high.
2. LOAD addr=0, m=2, n=2; bench drives mem_load_ack_in 4 cycles after load_en_out rises -> load_en_out high exactly 5 cycles, done_out one cycle later, reg_valid_out=2'b01. Then STORE addr=0 -> store_en_out high until reg_store_complete_in, done_out pulse.
3. STORE addr=1 after reset -> no enable, error_out at T2, error_code_out=ERR_INVALID_REG. LOAD m=0 -> ERR_SIZE. LOAD m=M+1 -> ERR_SIZE.
4. LOAD addr=1 with mem_load_error_in and mem_load_ack_in in the same cycle -> ERR_MEM, reg_valid_out[1] stays 0.
5. LOAD with no response, TIMEOUT_CYCLES=8 -> load_en_out high exactly 8 cycles, then error_out with ERR_TIMEOUT. Next accept clears error_code_out to ERR_NONE.
6. rst driven low in the 3rd cycle of LOAD, off the clock edge -> load_en_out and reg_valid_out go to 0 immediately. After release, op_ready_out=1 on the first posedge.

Source files
------------

// File: rtl/mpu_pkg.sv
// rtl/mpu_pkg.sv - shared MPU types, sizes and load/store controller definitions
package mpu_pkg;

    // Global matrix geometry
    localparam int MATRIX_REG_SIZE = 1;
    localparam int MPU_M           = 4;
    localparam int MPU_N           = 4;
    localparam int MBITS           = $clog2(MPU_M);
    localparam int NBITS           = $clog2(MPU_N);

    localparam int CTRL_TIMEOUT_DEFAULT = 64;

    typedef enum logic [1:0] {
        MPU_NOP   = 2'd0,
        MPU_LOAD  = 2'd1,
        MPU_STORE = 2'd2
    } mpu_operation_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        LOAD  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4,
        ERROR = 3'd5
    } mpu_ctrl_state_t;

    typedef enum logic [2:0] {
        ERR_NONE        = 3'd0,
        ERR_SIZE        = 3'd1,
        ERR_INVALID_REG = 3'd2,
        ERR_MEM         = 3'd3,
        ERR_TIMEOUT     = 3'd4,
        ERR_ILLEGAL_OP  = 3'd5
    } mpu_ctrl_err_t;

    // A dimension is legal when it is non-zero and no larger than the maximum.
    function automatic logic size_bad(input logic [MBITS:0] m, input logic [NBITS:0] n,
                                      input int max_m, input int max_n);
        return (m == '0) || (int'(m) > max_m) || (n == '0) || (int'(n) > max_n);
    endfunction

endpackage

// File: rtl/mpu_ctrl_timeout.sv
// rtl/mpu_ctrl_timeout.sv - resettable down-counter flagging an overlong enable
//
// Ports: clk, rst (async active-low), load (preset to TIMEOUT_CYCLES-1),
//        en (count down while non-zero), expired (count has reached zero).
module mpu_ctrl_timeout
    import mpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CTRL_TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);

    logic [CW-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= CW'(TIMEOUT_CYCLES - 1);
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Preset to N-1 on entry, so zero is reached in the N-th enabled cycle.
    assign expired = (count == '0);

endmodule

// File: rtl/mpu_ls_controller.sv
// rtl/mpu_ls_controller.sv - sequencer for the MPU load/store datapath
//
// Ports: clk, rst (async active-low); op_valid_in/op_ready_out handshake with
//        op_in, op_addr_in, op_m_in, op_n_in; load_en_out/store_en_out enables;
//        mem_load_ack_in, mem_load_error_in, reg_store_complete_in responses;
//        ctrl_addr_out/ctrl_m_out/ctrl_n_out latched operands; done_out and
//        error_out pulses with error_code_out; reg_valid_out scoreboard.
module mpu_ls_controller
    import mpu_pkg::*;
#(
    parameter int NUM_REGS       = 2**MATRIX_REG_SIZE,
    parameter int TIMEOUT_CYCLES = CTRL_TIMEOUT_DEFAULT,
    parameter int M              = MPU_M,
    parameter int N              = MPU_N
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       op_valid_in,
    output logic                       op_ready_out,
    input  mpu_operation_t             op_in,
    input  logic [MATRIX_REG_SIZE-1:0] op_addr_in,
    input  logic [MBITS:0]             op_m_in,
    input  logic [NBITS:0]             op_n_in,
    output logic                       load_en_out,
    output logic                       store_en_out,
    input  logic                       mem_load_ack_in,
    input  logic                       mem_load_error_in,
    input  logic                       reg_store_complete_in,
    output logic [MATRIX_REG_SIZE-1:0] ctrl_addr_out,
    output logic [MBITS:0]             ctrl_m_out,
    output logic [NBITS:0]             ctrl_n_out,
    output logic                       done_out,
    output logic                       error_out,
    output logic [2:0]                 error_code_out,
    output logic [NUM_REGS-1:0]        reg_valid_out
);

    mpu_ctrl_state_t state_q, state_d;
    mpu_operation_t  ctrl_op;
    mpu_ctrl_err_t   err_q, err_d;
    logic            err_set;
    logic            set_valid;
    logic            tmo_load, tmo_en, tmo_expired;
    logic            accept;

    assign accept         = (state_q == IDLE) && op_valid_in && op_ready_out;
    assign error_code_out = err_q;

    mpu_ctrl_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .load   (tmo_load),
        .en     (tmo_en),
        .expired(tmo_expired)
    );

    always_comb begin
        state_d   = state_q;
        err_d     = ERR_NONE;
        err_set   = 1'b0;
        set_valid = 1'b0;
        tmo_load  = 1'b0;
        tmo_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) state_d = CHECK;
            end
            CHECK: begin
                tmo_load = 1'b1;
                case (ctrl_op)
                    MPU_NOP: state_d = DONE;
                    MPU_LOAD, MPU_STORE: begin
                        if (size_bad(ctrl_m_out, ctrl_n_out, M, N)) begin
                            state_d = ERROR;
                            err_d   = ERR_SIZE;
                            err_set = 1'b1;
                        end else if ((ctrl_op == MPU_STORE) && !reg_valid_out[ctrl_addr_out]) begin
                            state_d = ERROR;
                            err_d   = ERR_INVALID_REG;
                            err_set = 1'b1;
                        end else begin
                            state_d = (ctrl_op == MPU_LOAD) ? LOAD : STORE;
                        end
                    end
                    default: begin
                        state_d = ERROR;
                        err_d   = ERR_ILLEGAL_OP;
                        err_set = 1'b1;
                    end
                endcase
            end
            LOAD: begin
                tmo_en = 1'b1;
                // Error beats ack; ack beats a timeout landing in the same cycle.
                if (mem_load_error_in) begin
                    state_d = ERROR;
                    err_d   = ERR_MEM;
                    err_set = 1'b1;
                end else if (mem_load_ack_in) begin
                    state_d   = DONE;
                    set_valid = 1'b1;
                end else if (tmo_expired) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                    err_set = 1'b1;
                end
            end
            STORE: begin
                tmo_en = 1'b1;
                if (reg_store_complete_in) begin
                    state_d = DONE;
                end else if (tmo_expired) begin
                    state_d = ERROR;
                    err_d   = ERR_TIMEOUT;
                    err_set = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            ERROR:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they line up with the
    // state register and all drop asynchronously on reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IDLE;
            op_ready_out  <= 1'b0;
            load_en_out   <= 1'b0;
            store_en_out  <= 1'b0;
            done_out      <= 1'b0;
            error_out     <= 1'b0;
            err_q         <= ERR_NONE;
            reg_valid_out <= '0;
            ctrl_op       <= MPU_NOP;
            ctrl_addr_out <= '0;
            ctrl_m_out    <= '0;
            ctrl_n_out    <= '0;
        end else begin
            state_q      <= state_d;
            op_ready_out <= (state_d == IDLE);
            load_en_out  <= (state_d == LOAD);
            store_en_out <= (state_d == STORE);
            done_out     <= (state_d == DONE);
            error_out    <= (state_d == ERROR);
            if (accept) begin
                ctrl_op       <= op_in;
                ctrl_addr_out <= op_addr_in;
                ctrl_m_out    <= op_m_in;
                ctrl_n_out    <= op_n_in;
                err_q         <= ERR_NONE;
            end else if (err_set) begin
                err_q <= err_d;
            end
            if (set_valid) reg_valid_out[ctrl_addr_out] <= 1'b1;
        end
    end

endmodule
